// File: rtl/lpm_walker.sv
// lpm_walker: longest-prefix-match multibit trie walker.
// It issues one memory read per trie level and returns the next hop, or a miss, tagged with a 4-bit ticket.
// Optional statistics counters are built only when LPM_WALKER_STATS_EN is defined.
module lpm_walker #(
    parameter int unsigned STRIDE     = 8,
    parameter int unsigned LEVELS     = 4,
    parameter logic [31:0] ROOT_BASE  = 32'h0000_0000,
    parameter logic [31:0] MISS_VALUE = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enter__ENA,
    input  logic [31:0] enter_key,
    output logic        enter__RDY,
    output logic [31:0] result,
    output logic        result_hit,
    output logic [3:0]  result_ticket,
    output logic        result__RDY,
    input  logic        resultAccept__ENA,
    output logic        resultAccept__RDY,
    output logic        mem_req__ENA,
    output logic [31:0] mem_req_v,
    input  logic        mem_req__RDY,
    output logic        mem_resAccept__ENA,
    input  logic        mem_resAccept__RDY,
    input  logic [31:0] mem_resValue,
    input  logic        mem_resValue__RDY
`ifdef LPM_WALKER_STATS_EN
    ,
    output logic [31:0] statLookups,
    output logic [31:0] statMemReads,
    output logic [15:0] statMisses
`endif
);

    localparam int unsigned LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_key;
    logic [DATA_W-1:0]   r_addr;
    logic [LVL_W-1:0]    r_level;
    logic [3:0]          r_ticket_cnt;
    logic [DATA_W-1:0]   r_result;
    logic                r_hit;
    logic [3:0]          r_ticket;

    logic                w_req_fire;
    logic                w_acc_fire;
    logic                w_last_level;
    logic [DATA_W-1:0]   w_next_addr;

    // Key slice for a given trie level: the STRIDE bits below the already-consumed prefix, zero-extended
    function automatic logic [DATA_W-1:0] chunk(input logic [DATA_W-1:0] key, input int unsigned lvl);
        logic [DATA_W-1:0] shifted;
        shifted = key << (lvl * STRIDE);
        chunk   = DATA_W'(shifted[DATA_W-1 -: STRIDE]);
    endfunction

    // Handshake decode: request and accept are gated directly by the memory-side ready signals
    assign w_req_fire   = (r_state == S_ISSUE) && mem_req__RDY;
    assign w_acc_fire   = (r_state == S_WAIT) && mem_resValue__RDY && mem_resAccept__RDY;
    assign w_last_level = (r_level == LVL_W'(LEVELS - 1));
    assign w_next_addr  = {1'b0, mem_resValue[30:0]} + chunk(r_key, 32'(r_level) + 32'd1);

    assign enter__RDY         = (r_state == S_IDLE);
    assign result__RDY        = (r_state == S_DONE);
    assign resultAccept__RDY  = (r_state == S_DONE);
    assign mem_req__ENA       = w_req_fire;
    assign mem_req_v          = r_addr;
    assign mem_resAccept__ENA = w_acc_fire;
    assign result             = r_result;
    assign result_hit         = r_hit;
    assign result_ticket      = r_ticket;

    // Walker FSM: one read per level, leaf or last level terminates the walk
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_key        <= '0;
            r_addr       <= '0;
            r_level      <= '0;
            r_ticket_cnt <= '0;
            r_result     <= '0;
            r_hit        <= 1'b0;
            r_ticket     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enter__ENA) begin
                        r_key        <= enter_key;
                        r_ticket     <= r_ticket_cnt;
                        r_ticket_cnt <= r_ticket_cnt + 4'd1;
                        r_addr       <= ROOT_BASE + chunk(enter_key, 32'd0);
                        r_level      <= '0;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_req__RDY) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_acc_fire) begin
                        if (mem_resValue[31]) begin
                            r_result <= {1'b0, mem_resValue[30:0]};
                            r_hit    <= 1'b1;
                            r_state  <= S_DONE;
                        end else if (w_last_level) begin
                            r_result <= MISS_VALUE;
                            r_hit    <= 1'b0;
                            r_state  <= S_DONE;
                        end else begin
                            r_addr  <= w_next_addr;
                            r_level <= r_level + LVL_W'(1);
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (resultAccept__ENA) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LPM_WALKER_STATS_EN
    logic [31:0] r_stat_lookups;
    logic [31:0] r_stat_reads;
    logic [15:0] r_stat_misses;

    assign statLookups  = r_stat_lookups;
    assign statMemReads = r_stat_reads;
    assign statMisses   = r_stat_misses;

    // Saturating event counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_stat_lookups <= '0;
            r_stat_reads   <= '0;
            r_stat_misses  <= '0;
        end else begin
            if ((r_state == S_IDLE) && enter__ENA && (r_stat_lookups != '1)) begin
                r_stat_lookups <= r_stat_lookups + 32'd1;
            end
            if (w_req_fire && (r_stat_reads != '1)) begin
                r_stat_reads <= r_stat_reads + 32'd1;
            end
            if (w_acc_fire && !mem_resValue[31] && w_last_level && (r_stat_misses != '1)) begin
                r_stat_misses <= r_stat_misses + 16'd1;
            end
        end
    end
`endif

    // A new key may only be offered while the walker is idle
    a_enter_when_idle: assert property (@(posedge CLK) disable iff (RST) enter__ENA |-> (r_state == S_IDLE));

endmodule
